axi_pack_outstanding_limiter: RTL and testbench

AXI_PACK_OUTSTANDING_LIMITER -- requirements
Module: axi_pack_outstanding_limiter

---
 rtl/axi_pack_filter_parallel_wrap_pkg.sv | 98 +++++++++
 rtl/axi_pack_credit_cnt.sv | 45 ++++
 rtl/axi_pack_outstanding_limiter.sv | 98 +++++++++
 tb/tb_axi_pack_outstanding_limiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pack_filter_parallel_wrap_pkg.sv
// Shared types for the pack-filter wrapper: 9-bit-ID AXI bus and limiter defaults.
package axi_pack_filter_parallel_wrap_pkg;

  localparam int unsigned IdWidth   = 9;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned UserWidth = 1;

  // Width of every in-flight counter; limits above 255 are not representable.
  localparam int unsigned CntWidth = 8;

  localparam int unsigned DefaultMaxReads  = 8;
  localparam int unsigned DefaultMaxWrites = 8;

  typedef logic [IdWidth-1:0]   axi_id_t;
  typedef logic [AddrWidth-1:0] axi_addr_t;
  typedef logic [DataWidth-1:0] axi_data_t;
  typedef logic [StrbWidth-1:0] axi_strb_t;
  typedef logic [UserWidth-1:0] axi_user_t;

  typedef struct packed {
    axi_id_t    id;
    axi_addr_t  addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    axi_user_t  user;
  } axi_idext_aw_chan_t;

  typedef struct packed {
    axi_data_t data;
    axi_strb_t strb;
    logic      last;
    axi_user_t user;
  } axi_idext_w_chan_t;

  typedef struct packed {
    axi_id_t    id;
    logic [1:0] resp;
    axi_user_t  user;
  } axi_idext_b_chan_t;

  typedef struct packed {
    axi_id_t    id;
    axi_addr_t  addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    axi_user_t  user;
  } axi_idext_ar_chan_t;

  typedef struct packed {
    axi_id_t    id;
    axi_data_t  data;
    logic [1:0] resp;
    logic       last;
    axi_user_t  user;
  } axi_idext_r_chan_t;

  typedef struct packed {
    axi_idext_aw_chan_t aw;
    logic               aw_valid;
    axi_idext_w_chan_t  w;
    logic               w_valid;
    logic               b_ready;
    axi_idext_ar_chan_t ar;
    logic               ar_valid;
    logic               r_ready;
  } axi_idext_req_t;

  typedef struct packed {
    logic              aw_ready;
    logic              ar_ready;
    logic              w_ready;
    logic              b_valid;
    axi_idext_b_chan_t b;
    logic              r_valid;
    axi_idext_r_chan_t r;
  } axi_idext_rsp_t;

  // Limit expressed at counter width, for comparison against a counter value.
  function automatic logic [CntWidth-1:0] cnt_limit(int unsigned max);
    return CntWidth'(max);
  endfunction

endpackage

// File: rtl/axi_pack_credit_cnt.sv
// Up/down counter tracking in-flight items; saturates at zero on a stray decrement.
module axi_pack_credit_cnt
  import axi_pack_filter_parallel_wrap_pkg::*;
#(
  parameter int unsigned Max = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc and dec cancel, decrement at zero is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == cnt_limit(Max));
  assign empty_o = (cnt_q == '0);

  // A release with nothing in flight means the attached bus broke protocol.
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(dec_i && !inc_i && empty_o));

endmodule

// File: rtl/axi_pack_outstanding_limiter.sv
// Caps in-flight AR/AW transactions and holds W beats until their AW has been sent.
module axi_pack_outstanding_limiter
  import axi_pack_filter_parallel_wrap_pkg::*;
#(
  parameter int unsigned MaxReads  = DefaultMaxReads,
  parameter int unsigned MaxWrites = DefaultMaxWrites,
  parameter type axi_req_t = axi_idext_req_t,
  parameter type axi_rsp_t = axi_idext_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  axi_req_t            slv_req_i,
  output axi_rsp_t            slv_rsp_o,
  output axi_req_t            mst_req_o,
  input  axi_rsp_t            mst_rsp_i,
  output logic [CntWidth-1:0] rd_outstanding_o,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic                idle_o
);

  logic                rd_full, rd_empty;
  logic                wr_full, wr_empty;
  logic                wc_empty, unused_wc_full;
  logic [CntWidth-1:0] rd_cnt, wr_cnt, unused_wc_cnt;
  logic                w_open;
  logic                ar_fwd_valid, aw_fwd_valid, w_fwd_valid;
  logic                ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;

  // Gates depend only on registered counts, never on the same channel's ready.
  assign w_open       = ~wc_empty;
  assign ar_fwd_valid = slv_req_i.ar_valid & ~rd_full;
  assign aw_fwd_valid = slv_req_i.aw_valid & ~wr_full;
  assign w_fwd_valid  = slv_req_i.w_valid & w_open;

  assign ar_hs     = ar_fwd_valid & mst_rsp_i.ar_ready;
  assign aw_hs     = aw_fwd_valid & mst_rsp_i.aw_ready;
  assign w_last_hs = w_fwd_valid & mst_rsp_i.w_ready & slv_req_i.w.last;
  assign r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
  assign b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;

  // Request path: payloads straight through, only the gated valids overridden.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = ar_fwd_valid;
    mst_req_o.aw_valid = aw_fwd_valid;
    mst_req_o.w_valid  = w_fwd_valid;
  end

  // Response path: payloads straight through, only the gated readies overridden.
  always_comb begin
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ~rd_full;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & ~wr_full;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready & w_open;
  end

  axi_pack_credit_cnt #(
    .Max (MaxReads)
  ) u_rd_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (ar_hs),
    .dec_i   (r_last_hs),
    .cnt_o   (rd_cnt),
    .full_o  (rd_full),
    .empty_o (rd_empty)
  );

  axi_pack_credit_cnt #(
    .Max (MaxWrites)
  ) u_wr_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (aw_hs),
    .dec_i   (b_hs),
    .cnt_o   (wr_cnt),
    .full_o  (wr_full),
    .empty_o (wr_empty)
  );

  // W credit: AWs sent whose last W beat has not yet gone out. Bounded by wr_cnt.
  axi_pack_credit_cnt #(
    .Max (MaxWrites)
  ) u_w_credit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (aw_hs),
    .dec_i   (w_last_hs),
    .cnt_o   (unused_wc_cnt),
    .full_o  (unused_wc_full),
    .empty_o (wc_empty)
  );

  assign rd_outstanding_o = rd_cnt;
  assign wr_outstanding_o = wr_cnt;
  assign idle_o           = rd_empty & wr_empty & wc_empty;

endmodule

// File: tb/tb_axi_pack_outstanding_limiter.sv
// Bench: directed corner cases plus randomized write-then-read traffic to a memory model.
module tb_axi_pack_outstanding_limiter;
  import axi_pack_filter_parallel_wrap_pkg::*;

  localparam int MaxRd  = 5;
  localparam int MaxWr  = 4;
  localparam int NumTxn = 400;

  logic           clk;
  logic           rst;
  axi_idext_req_t slv_req, mst_req;
  axi_idext_rsp_t slv_rsp, mst_rsp;
  logic [7:0]     rd_out, wr_out;
  logic           idle;

  axi_pack_outstanding_limiter #(
    .MaxReads  (MaxRd),
    .MaxWrites (MaxWr),
    .axi_req_t (axi_idext_req_t),
    .axi_rsp_t (axi_idext_rsp_t)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .slv_req_i        (slv_req),
    .slv_rsp_o        (slv_rsp),
    .mst_req_o        (mst_req),
    .mst_rsp_i        (mst_rsp),
    .rd_outstanding_o (rd_out),
    .wr_outstanding_o (wr_out),
    .idle_o           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: transactions in flight as seen at the bench boundary.
  int m_rd, m_wr, m_wc;
  bit hs_ar, hs_aw, hs_w, hs_wl, hs_r, hs_rl, hs_b;

  // Random-traffic state.
  int          tlen [NumTxn];
  logic [31:0] tdata [NumTxn][4];
  logic [31:0] exp_mem [int];
  logic [31:0] mem [int];
  int          dn_aw_addr [$];
  int          dn_ar_addr [$];
  int          dn_ar_len [$];
  int          dn_b_cnt, dn_wbeat, dn_rbeat;
  int          ai, wi, wb, ri, rr, rrb, bdone;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    slv_req = '0;
    mst_rsp = '0;
  endtask

  // Compare all outputs against the reference, then note which handshakes happen.
  task automatic sample();
    bit ar_ok, aw_ok, w_ok;
    #1;
    ar_ok = (m_rd < MaxRd);
    aw_ok = (m_wr < MaxWr);
    w_ok  = (m_wc > 0);
    check_eq("mst_ar_valid", mst_req.ar_valid, slv_req.ar_valid & ar_ok);
    check_eq("mst_aw_valid", mst_req.aw_valid, slv_req.aw_valid & aw_ok);
    check_eq("mst_w_valid", mst_req.w_valid, slv_req.w_valid & w_ok);
    check_eq("slv_ar_ready", slv_rsp.ar_ready, mst_rsp.ar_ready & ar_ok);
    check_eq("slv_aw_ready", slv_rsp.aw_ready, mst_rsp.aw_ready & aw_ok);
    check_eq("slv_w_ready", slv_rsp.w_ready, mst_rsp.w_ready & w_ok);
    check_eq("ar_payload", mst_req.ar, slv_req.ar);
    check_eq("aw_payload", mst_req.aw, slv_req.aw);
    check_eq("w_payload", mst_req.w, slv_req.w);
    check_eq("r_payload", slv_rsp.r, mst_rsp.r);
    check_eq("b_payload", slv_rsp.b, mst_rsp.b);
    check_eq("r_valid", slv_rsp.r_valid, mst_rsp.r_valid);
    check_eq("b_valid", slv_rsp.b_valid, mst_rsp.b_valid);
    check_eq("r_ready", mst_req.r_ready, slv_req.r_ready);
    check_eq("b_ready", mst_req.b_ready, slv_req.b_ready);
    check_eq("rd_outstanding", rd_out, m_rd);
    check_eq("wr_outstanding", wr_out, m_wr);
    check_eq("idle", idle, (m_rd == 0) && (m_wr == 0) && (m_wc == 0));
    hs_ar = slv_req.ar_valid && ar_ok && mst_rsp.ar_ready;
    hs_aw = slv_req.aw_valid && aw_ok && mst_rsp.aw_ready;
    hs_w  = slv_req.w_valid && w_ok && mst_rsp.w_ready;
    hs_wl = hs_w && slv_req.w.last;
    hs_r  = mst_rsp.r_valid && slv_req.r_ready;
    hs_rl = hs_r && mst_rsp.r.last;
    hs_b  = mst_rsp.b_valid && slv_req.b_ready;
  endtask

  // Clock edge: apply noted handshakes to the reference, return at the falling edge.
  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      m_rd = 0;
      m_wr = 0;
      m_wc = 0;
    end else begin
      m_rd = m_rd + int'(hs_ar) - int'(hs_rl);
      m_wr = m_wr + int'(hs_aw) - int'(hs_b);
      m_wc = m_wc + int'(hs_aw) - int'(hs_wl);
      if (m_rd < 0) m_rd = 0;
      if (m_wr < 0) m_wr = 0;
      if (m_wc < 0) m_wc = 0;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic clear_hs();
    hs_ar = 0; hs_aw = 0; hs_w = 0; hs_wl = 0; hs_r = 0; hs_rl = 0; hs_b = 0;
  endtask

  // Protocol-compliant random upstream master and downstream memory.
  task automatic drive_random(input bit wr_phase);
    if (hs_aw) slv_req.aw_valid = 1'b0;
    if (hs_w)  slv_req.w_valid  = 1'b0;
    if (hs_ar) slv_req.ar_valid = 1'b0;
    if (hs_r)  mst_rsp.r_valid  = 1'b0;
    if (hs_b)  mst_rsp.b_valid  = 1'b0;
    if (wr_phase) begin
      if (!slv_req.aw_valid && ai < NumTxn && $urandom_range(0, 1) == 1) begin
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'(ai * 4);
        slv_req.aw.len   = 8'(tlen[ai]);
        slv_req.aw.id    = 9'($urandom);
      end
      if (!slv_req.w_valid && wi < NumTxn && $urandom_range(0, 1) == 1) begin
        slv_req.w_valid = 1'b1;
        slv_req.w.data  = tdata[wi][wb];
        slv_req.w.strb  = '1;
        slv_req.w.last  = (wb == tlen[wi]);
      end
    end else begin
      if (!slv_req.ar_valid && ri < NumTxn && $urandom_range(0, 1) == 1) begin
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = 32'(ri * 4);
        slv_req.ar.len   = 8'(tlen[ri]);
        slv_req.ar.id    = 9'($urandom);
      end
    end
    if (!mst_rsp.r_valid && dn_ar_addr.size() != 0 && $urandom_range(0, 1) == 1) begin
      mst_rsp.r_valid = 1'b1;
      mst_rsp.r.data  = mem[dn_ar_addr[0] + dn_rbeat];
      mst_rsp.r.last  = (dn_rbeat == dn_ar_len[0]);
    end
    if (!mst_rsp.b_valid && dn_b_cnt > 0 && $urandom_range(0, 1) == 1) begin
      mst_rsp.b_valid = 1'b1;
      mst_rsp.b.resp  = 2'b00;
    end
    mst_rsp.aw_ready = 1'($urandom_range(0, 1));
    mst_rsp.w_ready  = 1'($urandom_range(0, 1));
    mst_rsp.ar_ready = 1'($urandom_range(0, 1));
    slv_req.r_ready  = 1'($urandom_range(0, 1));
    slv_req.b_ready  = 1'($urandom_range(0, 1));
  endtask

  // Track handshakes on both sides; memory is written from what leaves the DUT.
  task automatic bookkeep();
    if (hs_aw) begin
      dn_aw_addr.push_back(int'(mst_req.aw.addr));
      ai++;
    end
    if (hs_w) begin
      check_eq("w_has_aw", dn_aw_addr.size() != 0, 1'b1);
      if (dn_aw_addr.size() != 0) begin
        mem[dn_aw_addr[0] + dn_wbeat] = mst_req.w.data;
        dn_wbeat++;
        if (mst_req.w.last) begin
          void'(dn_aw_addr.pop_front());
          dn_wbeat = 0;
          dn_b_cnt++;
        end
      end
      wb++;
      if (wb > tlen[wi]) begin
        wi++;
        wb = 0;
      end
    end
    if (hs_b) begin
      dn_b_cnt--;
      bdone++;
    end
    if (hs_ar) begin
      dn_ar_addr.push_back(int'(mst_req.ar.addr));
      dn_ar_len.push_back(int'(mst_req.ar.len));
      ri++;
    end
    if (hs_r) begin
      check_eq("rd_data", slv_rsp.r.data, exp_mem[rr * 4 + rrb]);
      check_eq("rd_last", slv_rsp.r.last, rrb == tlen[rr]);
      rrb++;
      if (rrb > tlen[rr]) begin
        rr++;
        rrb = 0;
      end
      dn_rbeat++;
      if (mst_rsp.r.last) begin
        void'(dn_ar_addr.pop_front());
        void'(dn_ar_len.pop_front());
        dn_rbeat = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    clear_hs();
    m_rd = 0; m_wr = 0; m_wc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Held in reset with a request waiting: gates follow cleared counters.
    slv_req.ar_valid = 1'b1;
    mst_rsp.ar_ready = 1'b1;
    sample();
    check_eq("reset_idle", idle, 1'b1);
    check_eq("reset_rd_out", rd_out, 8'd0);
    check_eq("reset_wr_out", wr_out, 8'd0);
    clear_hs();
    advance();
    clear_inputs();
    rst = 1'b1;
    cycle();

    // Read saturation at MaxRd, then one R last reopens AR.
    mst_rsp.ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    repeat (MaxRd + 2) cycle();
    check_eq("rd_sat_cnt", rd_out, 8'(MaxRd));
    check_eq("rd_sat_ready", slv_rsp.ar_ready, 1'b0);
    check_eq("rd_sat_valid", mst_req.ar_valid, 1'b0);
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.last  = 1'b1;
    slv_req.r_ready = 1'b1;
    cycle();
    mst_rsp.r_valid = 1'b0;
    #1;
    check_eq("rd_reopen_valid", mst_req.ar_valid, 1'b1);
    cycle();
    check_eq("rd_refill_cnt", rd_out, 8'(MaxRd));
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid  = 1'b1;
    repeat (MaxRd) cycle();
    check_eq("rd_drained_idle", idle, 1'b1);
    clear_inputs();

    // W presented three cycles ahead of its AW.
    mst_rsp.w_ready  = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b1;
    slv_req.w.data   = 32'hcafe_0001;
    repeat (3) cycle();
    check_eq("w_early_held", mst_req.w_valid, 1'b0);
    slv_req.aw_valid = 1'b1;
    cycle();
    slv_req.aw_valid = 1'b0;
    #1;
    check_eq("w_after_aw", mst_req.w_valid, 1'b1);
    cycle();
    slv_req.w_valid = 1'b0;
    check_eq("w_wait_b_idle", idle, 1'b0);
    mst_rsp.b_valid = 1'b1;
    slv_req.b_ready = 1'b1;
    cycle();
    mst_rsp.b_valid = 1'b0;
    check_eq("w_done_idle", idle, 1'b1);
    clear_inputs();

    // Simultaneous increment and decrement on the read count.
    mst_rsp.ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    cycle();
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.last  = 1'b1;
    slv_req.r_ready = 1'b1;
    cycle();
    check_eq("rd_simul", rd_out, 8'd1);
    slv_req.ar_valid = 1'b0;
    cycle();
    clear_inputs();
    // Same for AW against B.
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.w_ready  = 1'b1;
    slv_req.aw_valid = 1'b1;
    cycle();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b1;
    cycle();
    slv_req.w_valid  = 1'b0;
    slv_req.aw_valid = 1'b1;
    mst_rsp.b_valid  = 1'b1;
    slv_req.b_ready  = 1'b1;
    cycle();
    check_eq("wr_simul", wr_out, 8'd1);
    slv_req.aw_valid = 1'b0;
    mst_rsp.b_valid  = 1'b0;
    slv_req.w_valid  = 1'b1;
    cycle();
    slv_req.w_valid = 1'b0;
    mst_rsp.b_valid = 1'b1;
    cycle();
    check_eq("wr_simul_idle", idle, 1'b1);
    clear_inputs();

    // Four 4-beat bursts with B withheld.
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.w_ready  = 1'b1;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.len   = 8'd3;
    repeat (4) cycle();
    slv_req.aw_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      slv_req.w_valid = 1'b1;
      slv_req.w.data  = 32'(i);
      slv_req.w.last  = ((i % 4) == 3);
      cycle();
    end
    check_eq("burst_wr_out", wr_out, 8'd4);
    #1;
    check_eq("burst_no_credit", mst_req.w_valid, 1'b0);
    slv_req.w_valid = 1'b0;
    mst_rsp.b_valid = 1'b1;
    slv_req.b_ready = 1'b1;
    repeat (4) cycle();
    check_eq("burst_idle", idle, 1'b1);
    clear_inputs();

    // Reset in the middle of traffic.
    mst_rsp.ar_ready = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      slv_req.ar_valid = 1'b1;
      slv_req.aw_valid = (i < 3);
      cycle();
    end
    check_eq("pre_rst_rd", rd_out, 8'd5);
    check_eq("pre_rst_wr", wr_out, 8'd3);
    clear_inputs();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check_eq("post_rst_rd", rd_out, 8'd0);
    check_eq("post_rst_wr", wr_out, 8'd0);
    check_eq("post_rst_idle", idle, 1'b1);
    cycle();

    // Random traffic: write everything, then read it all back.
    for (int i = 0; i < NumTxn; i++) begin
      tlen[i] = int'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) begin
        tdata[i][b] = $urandom;
        if (b <= tlen[i]) exp_mem[i * 4 + b] = tdata[i][b];
      end
    end
    ai = 0; wi = 0; wb = 0; ri = 0; rr = 0; rrb = 0; bdone = 0;
    dn_b_cnt = 0; dn_wbeat = 0; dn_rbeat = 0;
    clear_hs();
    for (int cyc = 0; cyc < 20000 && bdone < NumTxn; cyc++) begin
      drive_random(1'b1);
      sample();
      bookkeep();
      advance();
    end
    check_eq("wr_phase_done", bdone, NumTxn);
    for (int cyc = 0; cyc < 20000 && rr < NumTxn; cyc++) begin
      drive_random(1'b0);
      sample();
      bookkeep();
      advance();
    end
    check_eq("rd_phase_done", rr, NumTxn);
    clear_inputs();
    clear_hs();
    cycle();
    check_eq("final_idle", idle, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
